// File: rtl/arb_pkg.sv
// Shared definitions for the sram-like arbiter: owner ids, size encodings,
// default depth and the request payload carried on the shared port.
package arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  localparam int unsigned OUTSTANDING_DEF = 2;

  // Tag FIFO entry: which requester owns an accepted transaction
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  // Address-phase payload steered from the granted requester to the port
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } req_pl_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order owner-tag FIFO, 1 bit wide, DEPTH entries.
// Ports: clk, resetn (async active-low), push/din write an owner tag,
// pop retires the head; full, empty and head describe current contents.
module arb_tag_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << PTR_W;

  logic [SLOTS-1:0] tags_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which also covers DEPTH==1
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = tags_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        tags_q[wr_ptr_q] <= din;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between the instruction and data requesters.
// Address phases are arbitrated (DATA > INST, or round-robin when
// SRAM_ARB_RR_EN is defined); a stalled grant is locked until accepted.
// Accepted owners are queued so in-order responses are routed back.
// Ports: clk, resetn; inst_* / data_* requester sides; mem_* shared port;
// arb_err flags a response that arrived with no outstanding transaction.
module sram_like_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned OUTSTANDING = OUTSTANDING_DEF,
  parameter int unsigned TAG_W       = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  req_pl_t inst_pl;
  req_pl_t data_pl;
  req_pl_t port_pl;
  logic    full;
  logic    empty;
  logic    head;
  logic    lock_q;
  logic    lock_owner_q;
  logic    both_pick;
  logic    grant;
  logic    req_go;
  logic    accept;
  logic    pop;

  assign inst_pl = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                     wstrb: inst_wstrb, wdata: inst_wdata};
  assign data_pl = '{wr: data_wr, size: data_size, addr: data_addr,
                     wstrb: data_wstrb, wdata: data_wdata};

`ifdef SRAM_ARB_RR_EN
  // Last accepted owner; on contention the other side wins next
  logic rr_last_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_last_q <= OWNER_INST;
    end else if (accept) begin
      rr_last_q <= grant;
    end
  end

  assign both_pick = ~rr_last_q;
`else
  assign both_pick = OWNER_DATA;
`endif

  // Grant selection: a stalled grant keeps the port until accepted
  always_comb begin
    grant = OWNER_INST;
    if (lock_q) begin
      grant = lock_owner_q;
    end else if (inst_req && data_req) begin
      grant = both_pick;
    end else if (data_req) begin
      grant = OWNER_DATA;
    end
  end

  // Everything toward the port and requesters is held low during reset
  assign req_go  = resetn & ~full & ((grant == OWNER_DATA) ? data_req : inst_req);
  assign accept  = req_go & mem_addr_ok;
  assign pop     = resetn & mem_data_ok & ~empty;
  assign port_pl = !resetn ? '0 : ((grant == OWNER_DATA) ? data_pl : inst_pl);

  assign mem_req   = req_go;
  assign mem_wr    = port_pl.wr;
  assign mem_size  = port_pl.size;
  assign mem_addr  = port_pl.addr;
  assign mem_wstrb = port_pl.wstrb;
  assign mem_wdata = port_pl.wdata;

  assign inst_addr_ok = accept & (grant == OWNER_INST);
  assign data_addr_ok = accept & (grant == OWNER_DATA);
  assign inst_data_ok = pop & (head == OWNER_INST);
  assign data_data_ok = pop & (head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Lock tracking and sticky orphan-response flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_INST;
      arb_err      <= 1'b0;
    end else begin
      if (req_go) begin
        lock_q       <= ~mem_addr_ok;
        lock_owner_q <= grant;
      end
      if (mem_data_ok && empty) begin
        arb_err <= 1'b1;
      end
    end
  end

  arb_tag_fifo #(
    .DEPTH (OUTSTANDING),
    .CNT_W (TAG_W)
  ) u_tag_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .din    (grant),
    .pop    (pop),
    .full   (full),
    .empty  (empty),
    .head   (head)
  );

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Shares one sram-like memory port between the CPU instruction requester (IF stage) and data requester (EXE/MEM stage). Arbitrates address-phase requests and records each accepted transaction's owner in an in-order tag FIFO. Routes each data_ok/rdata response back to the correct requester. Sits between mycpu_top's two sram-like masters and the single bridge port toward the AXI bridge or unified SRAM.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions; power of two, 1..8.
- TAG_W, 3, width of the FIFO occupancy counter; must be ≥ clog2(OUTSTANDING)+1.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction request valid
- inst_wr  in  1  write flag; always 0 in practice, still passed through
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  byte address
- inst_wstrb  in  4  byte strobes
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  instruction address phase accepted
- inst_data_ok  out  1  instruction response valid
- inst_rdata  out  32  read data (shared with data side)
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  same as inst_*
- data_addr_ok  out  1  data address phase accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  read data
- mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  1/1/2/32/4/32  shared port request
- mem_addr_ok  in  1  shared port address accepted
- mem_data_ok  in  1  shared port response valid
- mem_rdata  in  32  shared port read data
- arb_err  out  1  sticky flag: mem_data_ok arrived with the tag FIFO empty

Behaviour:
- Reset (async, resetn=0): FIFO rd/wr pointers and count=0, lock=0, lock_owner=INST, rr_last=INST, arb_err=0. All outputs 0 while in reset, except rdata, which follows mem_rdata.
- Full = (count==OUTSTANDING). When full, mem_req=0, and no addr_ok is issued to either requester.
- Grant, combinational, when not full:
  - If lock=1, grant=lock_owner.
  - Otherwise, fixed priority DATA > INST among asserted reqs.
- mem_* request fields are muxed from the granted requester. mem_req = granted req & ~full.
- Address acceptance: on mem_req & mem_addr_ok, the granted requester's addr_ok=1 in the same cycle (combinational pass-through of mem_addr_ok), and the owner id is pushed into the FIFO. The non-granted requester's addr_ok is always 0.
- Lock rule: if mem_req=1 and mem_addr_ok=0, set lock=1 and lock_owner=grant at the clock edge. Clear lock on the accepting handshake. This keeps mem_addr/size/wr stable until acceptance. The requester must hold req until addr_ok.
- Response: on mem_data_ok with count>0:
  - Pop the head.
  - Assert head-owner's data_ok the same cycle; the other requester's data_ok=0.
  - inst_rdata = data_rdata = mem_rdata, unconditionally.
- Response with count==0: data_ok outputs stay 0; arb_err is set and stays set until reset.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance. A push while full cannot occur, because mem_req=0.
- Responses are strictly in order; the FIFO is 1-bit wide (0=INST, 1=DATA). Pointers wrap modulo OUTSTANDING.
- Latency: zero added cycles in both the address and response paths (pure combinational steering plus FIFO bookkeeping).
- Reset mid-transaction discards all tags. Responses still in flight afterward set arb_err; the system must reset the downstream together with this block.

Optional Feature:
- SRAM_ARB_RR_EN defined:
  - With no lock held and both reqs asserted, grant the requester not equal to rr_last.
  - rr_last updates to the granted owner on each accepted handshake.
  - With only one req asserted, that requester wins.
- Undefined: fixed DATA > INST priority; the rr_last register is not instantiated.

Decomposition:
- Shared package arb_pkg:
  - OWNER_INST=1'b0, OWNER_DATA=1'b1
  - SIZE_BYTE/HALF/WORD encodings
  - default OUTSTANDING
- One sub-module: arb_tag_fifo (1-bit wide, depth OUTSTANDING; push/pop/full/empty/head, async active-low reset).

Test Plan:
- Both reqs asserted, count=0, mem_addr_ok=1 → mem_addr=data_addr, data_addr_ok=1, inst_addr_ok=0; next cycle count=1. Then mem_data_ok=1, mem_rdata=32'hDEADBEEF → data_data_ok=1, data_rdata=32'hDEADBEEF, inst_data_ok=0.
- inst_req alone with mem_addr_ok=0 for 3 cycles, data_req rising in cycle 2 → mem_addr stays inst_addr (locked); inst_addr_ok on cycle 4; data is granted next.
- OUTSTANDING=2: accept INST then DATA with no responses → third request sees mem_req=0. Two responses → inst_data_ok then data_data_ok, in order.
- With count=1, one cycle has push (mem_addr_ok) plus pop (mem_data_ok) → count stays 1 and the head owner is correct on the next response.
- mem_data_ok=1 with count=0 → no data_ok pulses, arb_err=1 and sticky; resetn=0 clears it asynchronously.
- SRAM_ARB_RR_EN defined, both reqs held, mem_addr_ok=1 every cycle → grants alternate DATA, INST, DATA, INST.
